weight1_reader: RTL

Read-side sequencer for the first-layer weight SRAM (16-bit signed, 156800 words = 200 neuron rows × 784 inputs). On a `start` command it fetches one neuron row of 784 weights in address order and presents them as a valid/ready stream with a `last` marker to the MAC datapath. Backpressure is absorbed by a 2-entry output buffer, so no SRAM read is ever lost or duplicated. The block sits between the top-level control FSM and the weight SRAM's read port.

---
 rtl/nn_pkg.sv | 24 ++
 rtl/w_skid_fifo.sv | 57 +++++
 rtl/weight1_reader.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared constants, FSM state encoding and stream beat type for the layer-1 weight path.
package nn_pkg;

    localparam int ROW_LEN  = 784;
    localparam int NUM_ROWS = 200;
    localparam int DW       = 16;
    localparam int AW       = 18;
    localparam int KW       = 10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    function automatic logic [AW-1:0] row_base(input logic [7:0] row);
        return AW'(row) * AW'(ROW_LEN);
    endfunction

endpackage

// File: rtl/w_skid_fifo.sv
// Two-entry output buffer (data + last) with a credit count for the read issuer.
module w_skid_fifo
    import nn_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       push_i,
    input  beat_t      push_beat_i,
    input  logic       ready_i,
    output beat_t      head_o,
    output logic       valid_o,
    output logic       pop_o,
    output logic [1:0] credit_o
);

    beat_t      mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] occ_q;
    logic [1:0] occ_d;

    assign valid_o = (occ_q != 2'd0);
    assign pop_o   = valid_o & ready_i;
    assign head_o  = mem_q[rd_ptr_q];

    // Free slots once this cycle's pop retires, so a read can issue alongside a pop.
    assign credit_o = 2'd2 - occ_q + {1'b0, pop_o};

    always_comb begin
        occ_d = occ_q;
        if (push_i && !pop_o) begin
            occ_d = occ_q + 2'd1;
        end else if (!push_i && pop_o) begin
            occ_d = occ_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_beat_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_o) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_d;
        end
    end

endmodule

// File: rtl/weight1_reader.sv
// Fetches one 784-weight neuron row from the layer-1 weight SRAM as a valid/ready stream.
// Optional running checksum of accepted weights: define WEIGHT1_READER_CHECKSUM_EN.
//
// state    | meaning
// IDLE     | waiting for start; first read of a legal row issues on the accepting edge's next cycle
// RUN      | issuing reads base+k while the buffer has credit
// DRAIN    | all reads issued; waiting for the last beat to be accepted
// FIN      | done pulse (an error entry spends one cycle here before pulsing)
module weight1_reader
    import nn_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          start_i,
    input  logic [7:0]    row_idx_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic          sram_we_o,
    output logic [DW-1:0] sram_d_o,
    output logic [AW-1:0] sram_addr_o,
    input  logic [DW-1:0] sram_q_i,
    output logic [DW-1:0] w_data_o,
    output logic          w_valid_o,
    input  logic          w_ready_i,
    output logic          w_last_o,
    output logic [31:0]   checksum_o
);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] addr_hold_q;
    logic [KW-1:0] rem_q, rem_d;
    logic          err_q, err_d;
    logic          done_q, done_d;
    logic          rd_vld_q;
    logic          rd_last_q;

    logic          issue;
    logic          last_pop;
    logic          fifo_pop;
    logic          fifo_valid;
    logic [1:0]    fifo_credit;
    beat_t         fifo_head;
    beat_t         push_beat;

    assign issue    = (state_q == ST_RUN) && (fifo_credit > {1'b0, rd_vld_q});
    assign last_pop = fifo_pop & fifo_head.last;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (row_idx_i >= 8'(NUM_ROWS)) begin
                        err_d   = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        err_d   = 1'b0;
                        addr_d  = row_base(row_idx_i);
                        rem_d   = KW'(ROW_LEN - 1);
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (issue) begin
                    addr_d = addr_q + AW'(1);
                    if (rem_q == '0) begin
                        state_d = ST_DRAIN;
                    end else begin
                        rem_d = rem_q - KW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (last_pop) begin
                    state_d = ST_FIN;
                    done_d  = 1'b1;
                end
            end
            ST_FIN: begin
                if (done_q) begin
                    state_d = ST_IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            addr_hold_q <= '0;
            rem_q       <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            err_q     <= err_d;
            done_q    <= done_d;
            rd_vld_q  <= issue;
            rd_last_q <= issue && (rem_q == '0);
            if (issue) begin
                addr_hold_q <= addr_q;
            end
        end
    end

    // The SRAM registers the address itself, so the issued address is presented in the issue cycle.
    assign sram_addr_o = issue ? addr_q : addr_hold_q;
    assign sram_we_o   = 1'b0;
    assign sram_d_o    = '0;

    assign push_beat.last = rd_last_q;
    assign push_beat.data = sram_q_i;

    w_skid_fifo u_fifo (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .push_i      (rd_vld_q),
        .push_beat_i (push_beat),
        .ready_i     (w_ready_i),
        .head_o      (fifo_head),
        .valid_o     (fifo_valid),
        .pop_o       (fifo_pop),
        .credit_o    (fifo_credit)
    );

    assign w_valid_o = fifo_valid;
    assign w_data_o  = fifo_head.data;
    assign w_last_o  = fifo_valid & fifo_head.last;

    assign busy_o = (state_q != ST_IDLE) && !done_q;
    assign done_o = done_q;
    assign err_o  = err_q;

`ifdef WEIGHT1_READER_CHECKSUM_EN
    logic [31:0] csum_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            csum_q <= '0;
        end else if ((state_q == ST_IDLE) && start_i) begin
            csum_q <= '0;
        end else if (fifo_pop) begin
            csum_q <= csum_q + {{(32-DW){w_data_o[DW-1]}}, w_data_o};
        end
    end

    assign checksum_o = csum_q;
`else
    assign checksum_o = '0;
`endif

endmodule
